ahb2apb_bridge: RTL and testbench
=================================

# ahb2apb_bridge

AHB-Lite slave to APB master bridge: accepts single word transfers from the AHB fabric and replays each one as an APB SETUP/ACCESS transfer to one of three APB peripherals (generic APB slot, GPIO, UART0). It is the mirror of the existing APB-to-AHB path and sits between the AHB interconnect and the APB peripheral cluster at BASE_ADDR. One outstanding transfer at a time; no write buffering.

## Interface

- BASE_ADDR, 32'h0200_0000, base of the 16 KB APB window (aligned to 16 KB)
- clk  input  1  system clock, all logic on rising edge
- reset_  input  1  reset; asynchronous, active-low
- HSEL  input  1  slave select from AHB decoder
- HADDR  input  32  address-phase address
- HWRITE  input  1  1 = write
- HSIZE  input  3  transfer size; only 3'b010 (word) supported
- HTRANS  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- HWDATA  input  32  write data (data phase)
- HREADY  input  1  bus-wide ready (previous transfer complete)
- HREADYOUT  output  1  this slave's ready
- HRESP  output  2  00 OKAY, 01 ERROR
- HRDATA  output  32  read data
- paddr  output  32  APB address
- pwdata  output  32  APB write data
- pwrite  output  1  APB direction
- psel  output  3  one-hot: [0] generic slot, [1] GPIO, [2] UART0
- penable  output  1  APB access phase
- prdata  input  32  read data, muxed by the APB cluster
- pready  input  1  APB ready, muxed by the APB cluster
- pslverr  input  1  APB error, muxed by the APB cluster

## Operation

- Accept: in IDLE or DONE, HSEL & HREADY & HTRANS[1] samples an address phase; register HADDR, HWRITE, decoded slot. BUSY/IDLE/unselected: no action, OKAY, HREADYOUT=1.
- Decode: hit when HADDR[31:14]==BASE_ADDR[31:14]; slot = HADDR[13:12]: 0 -> psel[0], 1 -> psel[1], 2 -> psel[2], 3 -> miss.
- Miss or HSIZE != 3'b010 -> ERR1 directly; no APB transfer issued.
- States: IDLE, LATCH, SETUP, ACCESS, DONE, ERR1, ERR2.
- IDLE: HREADYOUT=1, HRESP=OKAY. Accept -> LATCH (or ERR1).
- LATCH: HREADYOUT=0; capture HWDATA into pwdata (writes only; reads leave pwdata unchanged) -> SETUP.
- SETUP: psel[slot]=1, penable=0, HREADYOUT=0 -> ACCESS.
- ACCESS: psel[slot]=1, penable=1, HREADYOUT=0; stay while pready=0. pready & ~pslverr -> DONE; pready & pslverr -> ERR1. On pready with read, HRDATA <= prdata.
- DONE: HREADYOUT=1, HRESP=OKAY; psel=0, penable=0. Accept (pipelined next address) -> LATCH/ERR1, else IDLE.
- ERR1: HREADYOUT=0, HRESP=01. -> ERR2.
- ERR2: HREADYOUT=1, HRESP=01. Accept -> LATCH/ERR1, else IDLE (AHB master may cancel; a new address is still honoured).
- paddr, pwrite, psel, penable, pwdata, HRDATA, HREADYOUT, HRESP all registered outputs; paddr/pwrite stable from SETUP through ACCESS completion.
- HRDATA holds last captured read value; write or error responses do not change it.

## Timing

- Reset values: HREADYOUT=1, HRESP=00, HRDATA=0, paddr=0, pwdata=0, pwrite=0, psel=000, penable=0, state IDLE.
- Reset asserted mid-transfer: all outputs to reset values immediately (asynchronous); APB transfer abandoned; no response completed.
- Zero-wait APB transfer, address phase at cycle 0: LATCH c1, SETUP c2, ACCESS c3 (pready=1), DONE c4. HREADYOUT low c1-c3, high c4; read data valid on HRDATA at c4.
- Each APB wait cycle (pready=0 in ACCESS) adds exactly one HREADYOUT-low cycle.
- Error: HRESP=01 for two cycles, HREADYOUT 0 then 1. Decode/size error: address c0, ERR1 c1, ERR2 c2.
- Back-to-back: address accepted in DONE c4 -> LATCH c5, next psel at c6; psel deasserts for at least c4-c5 between transfers.
- psel is never asserted to more than one slot; penable never high without psel.

## Test plan

- Write 0x0200_1004 <- 0xDEADBEEF, pready tied 1 -> psel=010 c2, penable c3, pwdata=0xDEADBEEF c2-c3, HREADYOUT 0,0,0,1, HRESP=00.
- Read 0x0200_2000, prdata=0x0000_00A5, pready low 2 cycles in ACCESS -> HREADYOUT low 5 cycles, HRDATA=0x0000_00A5 when HREADYOUT rises, psel=100.
- Read 0x0200_3000 and write with HSIZE=3'b000 to 0x0200_0000 -> no psel activity, HRESP=01 two cycles, HREADYOUT 0 then 1.
- pslverr=1 with pready=1 on write to 0x0200_0008 -> ERR1/ERR2 sequence after ACCESS, HRDATA unchanged.
- Pipelined NONSEQ write then read issued during DONE -> second SETUP exactly 2 cycles after first DONE; BUSY and IDLE HTRANS interleaved produce no APB traffic.
- reset_ low during ACCESS -> psel=000, penable=0, HREADYOUT=1 same cycle; next transfer after release completes normally.

Source files
------------

// File: rtl/ahb2apb_bridge.sv
// ahb2apb_bridge
//
// Purpose:
//   AHB-Lite slave that replays single word transfers as APB SETUP/ACCESS
//   transfers to one of three APB peripherals in a 16 KB window at BASE_ADDR.
//   Only one transfer is in flight at a time; writes are not buffered, so the
//   AHB data phase is held with HREADYOUT low until the APB side completes.
//
// Ports:
//   clk, reset_      system clock (rising edge), asynchronous active-low reset
//   HSEL .. HREADY   AHB-Lite address/data phase inputs
//   HREADYOUT        this slave's ready (registered)
//   HRESP            00 OKAY, 01 ERROR (registered)
//   HRDATA           last successfully captured APB read data (registered)
//   paddr, pwdata    APB address and write data
//   pwrite           APB direction, 1 = write
//   psel[2:0]        one-hot: [0] generic slot, [1] GPIO, [2] UART0
//   penable          APB access phase
//   prdata, pready,
//   pslverr          muxed response from the APB cluster

module ahb2apb_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    output logic        pwrite,
    output logic [2:0]  psel,
    output logic        penable,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LATCH  = 3'd1;
    localparam logic [2:0] S_SETUP  = 3'd2;
    localparam logic [2:0] S_ACCESS = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERR1   = 3'd5;
    localparam logic [2:0] S_ERR2   = 3'd6;

    logic [2:0]  state_q, state_d;
    logic [1:0]  slot_q;
    logic [31:0] paddr_q, pwdata_q, hrdata_q;
    logic        pwrite_q, penable_q, hreadyout_q;
    logic        penable_d, hreadyout_d;
    logic [2:0]  psel_q, psel_d;
    logic [1:0]  hresp_q, hresp_d;

    logic        canAccept;
    logic        addrPhase;
    logic        addrOk;
    logic        goodAccept;
    logic        unused_htrans0;

    // HTRANS[0] only distinguishes NONSEQ from SEQ, which this bridge treats alike.
    assign unused_htrans0 = HTRANS[0];

    // A new address phase may only be taken while the previous response is
    // completing (or there is none); NONSEQ and SEQ both have HTRANS[1] set.
    assign canAccept  = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR2);
    assign addrPhase  = canAccept && HSEL && HREADY && HTRANS[1];
    assign addrOk     = (HADDR[31:14] == BASE_ADDR[31:14]) &&
                        (HADDR[13:12] != 2'b11) &&
                        (HSIZE == 3'b010);
    assign goodAccept = addrPhase && addrOk;

    // Next-state logic; decode or size errors skip the APB side entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR2: begin
                if (addrPhase) begin
                    state_d = addrOk ? S_LATCH : S_ERR1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LATCH:  state_d = S_SETUP;
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: begin
                if (pready) begin
                    state_d = pslverr ? S_ERR1 : S_DONE;
                end
            end
            S_ERR1:   state_d = S_ERR2;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output values are derived from the next state so every bus-facing
    // signal comes straight out of a flop in the cycle the state is entered.
    always_comb begin
        hreadyout_d = (state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERR2);
        hresp_d     = ((state_d == S_ERR1) || (state_d == S_ERR2)) ? 2'b01 : 2'b00;
        penable_d   = (state_d == S_ACCESS);
        psel_d      = 3'b000;
        if ((state_d == S_SETUP) || (state_d == S_ACCESS)) begin
            case (slot_q)
                2'd0:    psel_d = 3'b001;
                2'd1:    psel_d = 3'b010;
                2'd2:    psel_d = 3'b100;
                default: psel_d = 3'b000;
            endcase
        end
    end

    // Address/direction are captured at acceptance and held until the next
    // accepted transfer, which keeps them stable across SETUP and ACCESS.
    // Write data arrives in the AHB data phase, i.e. while in LATCH.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q     <= S_IDLE;
            slot_q      <= 2'd0;
            paddr_q     <= 32'h0;
            pwdata_q    <= 32'h0;
            pwrite_q    <= 1'b0;
            hrdata_q    <= 32'h0;
            psel_q      <= 3'b000;
            penable_q   <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 2'b00;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            if (goodAccept) begin
                paddr_q  <= HADDR;
                pwrite_q <= HWRITE;
                slot_q   <= HADDR[13:12];
            end
            if ((state_q == S_LATCH) && pwrite_q) begin
                pwdata_q <= HWDATA;
            end
            // Failed reads must not disturb the last good read value.
            if ((state_q == S_ACCESS) && pready && !pslverr && !pwrite_q) begin
                hrdata_q <= prdata;
            end
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = hrdata_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign pwrite    = pwrite_q;
    assign psel      = psel_q;
    assign penable   = penable_q;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// tb_ahb2apb_bridge
//
// Purpose:
//   Directed self-checking bench for ahb2apb_bridge. Inputs change 1 ns after
//   each rising edge and outputs are checked at that same point, so every
//   check sees the values registered at the edge that opened the cycle.
//
// Ports: none (top-level bench).

module tb_ahb2apb_bridge;

    logic        clk = 1'b0;
    logic        reset_;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic [2:0]  psel;
    logic        penable;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int total = 0;
    int bad   = 0;

    ahb2apb_bridge dut (
        .clk       (clk),
        .reset_    (reset_),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HTRANS    (HTRANS),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pwrite    (pwrite),
        .psel      (psel),
        .penable   (penable),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    // Single-slave fabric: the bus-wide ready is this slave's own ready.
    assign HREADY = HREADYOUT;

    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one AHB address phase (or idle it when sel is 0).
    task automatic applyStimulus(input logic sel, input logic [1:0] trans,
                                 input logic [31:0] addr, input logic write,
                                 input logic [2:0] size);
        HSEL   = sel;
        HTRANS = trans;
        HADDR  = addr;
        HWRITE = write;
        HSIZE  = size;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        reset_  = 1'b0;
        HWDATA  = 32'h0;
        prdata  = 32'h0;
        pready  = 1'b1;
        pslverr = 1'b0;
        applyStimulus(1'b0, 2'b00, 32'h0, 1'b0, 3'b010);

        // Reset state
        step();
        step();
        checkOutput("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
        checkOutput("rst_hresp",     {30'h0, HRESP},     32'h0);
        checkOutput("rst_hrdata",    HRDATA,             32'h0);
        checkOutput("rst_paddr",     paddr,              32'h0);
        checkOutput("rst_pwdata",    pwdata,             32'h0);
        checkOutput("rst_pwrite",    {31'h0, pwrite},    32'h0);
        checkOutput("rst_psel",      {29'h0, psel},      32'h0);
        checkOutput("rst_penable",   {31'h0, penable},   32'h0);
        reset_ = 1'b1;
        step();

        // Zero-wait write to GPIO
        applyStimulus(1'b1, 2'b10, 32'h0200_1004, 1'b1, 3'b010);
        checkOutput("w1_c0_hready", {31'h0, HREADYOUT}, 32'h1);
        step();
        checkOutput("w1_c1_hready", {31'h0, HREADYOUT}, 32'h0);
        checkOutput("w1_c1_psel",   {29'h0, psel},      32'h0);
        applyStimulus(1'b0, 2'b00, 32'h0, 1'b0, 3'b010);
        HWDATA = 32'hDEAD_BEEF;
        step();
        checkOutput("w1_c2_hready",  {31'h0, HREADYOUT}, 32'h0);
        checkOutput("w1_c2_psel",    {29'h0, psel},      32'h2);
        checkOutput("w1_c2_penable", {31'h0, penable},   32'h0);
        checkOutput("w1_c2_pwdata",  pwdata,             32'hDEAD_BEEF);
        checkOutput("w1_c2_paddr",   paddr,              32'h0200_1004);
        checkOutput("w1_c2_pwrite",  {31'h0, pwrite},    32'h1);
        step();
        checkOutput("w1_c3_hready",  {31'h0, HREADYOUT}, 32'h0);
        checkOutput("w1_c3_psel",    {29'h0, psel},      32'h2);
        checkOutput("w1_c3_penable", {31'h0, penable},   32'h1);
        checkOutput("w1_c3_pwdata",  pwdata,             32'hDEAD_BEEF);
        step();
        checkOutput("w1_c4_hready",  {31'h0, HREADYOUT}, 32'h1);
        checkOutput("w1_c4_hresp",   {30'h0, HRESP},     32'h0);
        checkOutput("w1_c4_psel",    {29'h0, psel},      32'h0);
        checkOutput("w1_c4_penable", {31'h0, penable},   32'h0);
        checkOutput("w1_c4_hrdata",  HRDATA,             32'h0);
        step();

        // Read from UART0 with two APB wait cycles
        prdata = 32'h0000_00A5;
        pready = 1'b0;
        applyStimulus(1'b1, 2'b10, 32'h0200_2000, 1'b0, 3'b010);
        step();
        checkOutput("r2_c1_hready", {31'h0, HREADYOUT}, 32'h0);
        applyStimulus(1'b0, 2'b00, 32'h0, 1'b0, 3'b010);
        step();
        checkOutput("r2_c2_hready",  {31'h0, HREADYOUT}, 32'h0);
        checkOutput("r2_c2_psel",    {29'h0, psel},      32'h4);
        checkOutput("r2_c2_pwrite",  {31'h0, pwrite},    32'h0);
        checkOutput("r2_c2_pwdata",  pwdata,             32'hDEAD_BEEF);
        step();
        checkOutput("r2_c3_hready",  {31'h0, HREADYOUT}, 32'h0);
        checkOutput("r2_c3_penable", {31'h0, penable},   32'h1);
        step();
        checkOutput("r2_c4_hready",  {31'h0, HREADYOUT}, 32'h0);
        checkOutput("r2_c4_psel",    {29'h0, psel},      32'h4);
        step();
        checkOutput("r2_c5_hready",  {31'h0, HREADYOUT}, 32'h0);
        checkOutput("r2_c5_penable", {31'h0, penable},   32'h1);
        checkOutput("r2_c5_hrdata",  HRDATA,             32'h0);
        pready = 1'b1;
        step();
        checkOutput("r2_c6_hready",  {31'h0, HREADYOUT}, 32'h1);
        checkOutput("r2_c6_hrdata",  HRDATA,             32'h0000_00A5);
        checkOutput("r2_c6_psel",    {29'h0, psel},      32'h0);
        step();

        // Decode error: slot 3 read
        applyStimulus(1'b1, 2'b10, 32'h0200_3000, 1'b0, 3'b010);
        step();
        checkOutput("e3_c1_hready", {31'h0, HREADYOUT}, 32'h0);
        checkOutput("e3_c1_hresp",  {30'h0, HRESP},     32'h1);
        checkOutput("e3_c1_psel",   {29'h0, psel},      32'h0);
        applyStimulus(1'b0, 2'b00, 32'h0, 1'b0, 3'b010);
        step();
        checkOutput("e3_c2_hready", {31'h0, HREADYOUT}, 32'h1);
        checkOutput("e3_c2_hresp",  {30'h0, HRESP},     32'h1);
        checkOutput("e3_c2_psel",   {29'h0, psel},      32'h0);
        step();
        checkOutput("e3_c3_hresp",  {30'h0, HRESP},     32'h0);

        // Size error: byte write inside the window
        applyStimulus(1'b1, 2'b10, 32'h0200_0000, 1'b1, 3'b000);
        step();
        checkOutput("e4_c1_hready", {31'h0, HREADYOUT}, 32'h0);
        checkOutput("e4_c1_hresp",  {30'h0, HRESP},     32'h1);
        applyStimulus(1'b0, 2'b00, 32'h0, 1'b0, 3'b010);
        HWDATA = 32'h0BAD_0BAD;
        step();
        checkOutput("e4_c2_hready", {31'h0, HREADYOUT}, 32'h1);
        checkOutput("e4_c2_hresp",  {30'h0, HRESP},     32'h1);
        checkOutput("e4_c2_psel",   {29'h0, psel},      32'h0);
        checkOutput("e4_c2_pwdata", pwdata,             32'hDEAD_BEEF);
        step();

        // Out-of-window address
        applyStimulus(1'b1, 2'b10, 32'h0300_1000, 1'b0, 3'b010);
        step();
        checkOutput("e5_c1_hresp", {30'h0, HRESP}, 32'h1);
        applyStimulus(1'b0, 2'b00, 32'h0, 1'b0, 3'b010);
        step();
        step();

        // APB slave error on write to generic slot
        pslverr = 1'b1;
        applyStimulus(1'b1, 2'b10, 32'h0200_0008, 1'b1, 3'b010);
        step();
        applyStimulus(1'b0, 2'b00, 32'h0, 1'b0, 3'b010);
        HWDATA = 32'h1234_5678;
        step();
        checkOutput("s6_c2_psel",    {29'h0, psel},      32'h1);
        step();
        checkOutput("s6_c3_penable", {31'h0, penable},   32'h1);
        step();
        checkOutput("s6_c4_hready",  {31'h0, HREADYOUT}, 32'h0);
        checkOutput("s6_c4_hresp",   {30'h0, HRESP},     32'h1);
        checkOutput("s6_c4_psel",    {29'h0, psel},      32'h0);
        checkOutput("s6_c4_penable", {31'h0, penable},   32'h0);
        pslverr = 1'b0;
        step();
        checkOutput("s6_c5_hready",  {31'h0, HREADYOUT}, 32'h1);
        checkOutput("s6_c5_hresp",   {30'h0, HRESP},     32'h1);
        checkOutput("s6_c5_hrdata",  HRDATA,             32'h0000_00A5);
        step();

        // BUSY and IDLE with HSEL high: no APB traffic
        applyStimulus(1'b1, 2'b01, 32'h0200_1000, 1'b1, 3'b010);
        step();
        checkOutput("b7_busy_hready", {31'h0, HREADYOUT}, 32'h1);
        checkOutput("b7_busy_psel",   {29'h0, psel},      32'h0);
        applyStimulus(1'b1, 2'b00, 32'h0200_1000, 1'b1, 3'b010);
        step();
        step();
        checkOutput("b7_idle_hready", {31'h0, HREADYOUT}, 32'h1);
        checkOutput("b7_idle_psel",   {29'h0, psel},      32'h0);

        // Pipelined write then read accepted during DONE
        prdata = 32'h5A5A_5A5A;
        applyStimulus(1'b1, 2'b10, 32'h0200_1000, 1'b1, 3'b010);
        step();
        applyStimulus(1'b0, 2'b00, 32'h0, 1'b0, 3'b010);
        HWDATA = 32'h1111_1111;
        step();
        checkOutput("p8_c2_psel", {29'h0, psel}, 32'h2);
        step();
        applyStimulus(1'b1, 2'b10, 32'h0200_0004, 1'b0, 3'b010);
        step();
        checkOutput("p8_c4_hready", {31'h0, HREADYOUT}, 32'h1);
        checkOutput("p8_c4_psel",   {29'h0, psel},      32'h0);
        step();
        checkOutput("p8_c5_hready", {31'h0, HREADYOUT}, 32'h0);
        checkOutput("p8_c5_psel",   {29'h0, psel},      32'h0);
        applyStimulus(1'b0, 2'b00, 32'h0, 1'b0, 3'b010);
        step();
        checkOutput("p8_c6_psel",    {29'h0, psel},    32'h1);
        checkOutput("p8_c6_penable", {31'h0, penable}, 32'h0);
        checkOutput("p8_c6_paddr",   paddr,            32'h0200_0004);
        checkOutput("p8_c6_pwrite",  {31'h0, pwrite},  32'h0);
        checkOutput("p8_c6_pwdata",  pwdata,           32'h1111_1111);
        step();
        step();
        checkOutput("p8_c8_hready", {31'h0, HREADYOUT}, 32'h1);
        checkOutput("p8_c8_hrdata", HRDATA,             32'h5A5A_5A5A);
        step();

        // Asynchronous reset in the middle of ACCESS
        pready = 1'b0;
        applyStimulus(1'b1, 2'b10, 32'h0200_2010, 1'b1, 3'b010);
        step();
        applyStimulus(1'b0, 2'b00, 32'h0, 1'b0, 3'b010);
        HWDATA = 32'hCAFE_F00D;
        step();
        step();
        checkOutput("r9_acc_penable", {31'h0, penable}, 32'h1);
        reset_ = 1'b0;
        #1;
        checkOutput("r9_rst_psel",    {29'h0, psel},      32'h0);
        checkOutput("r9_rst_penable", {31'h0, penable},   32'h0);
        checkOutput("r9_rst_hready",  {31'h0, HREADYOUT}, 32'h1);
        checkOutput("r9_rst_hrdata",  HRDATA,             32'h0);
        checkOutput("r9_rst_pwdata",  pwdata,             32'h0);
        step();
        step();
        reset_ = 1'b1;
        pready = 1'b1;
        step();

        // Transfer after reset release completes normally
        prdata = 32'h00C0_FFEE;
        applyStimulus(1'b1, 2'b10, 32'h0200_1008, 1'b0, 3'b010);
        step();
        applyStimulus(1'b0, 2'b00, 32'h0, 1'b0, 3'b010);
        step();
        checkOutput("a10_c2_psel",  {29'h0, psel},      32'h2);
        checkOutput("a10_c2_paddr", paddr,              32'h0200_1008);
        step();
        step();
        checkOutput("a10_c4_hready", {31'h0, HREADYOUT}, 32'h1);
        checkOutput("a10_c4_hresp",  {30'h0, HRESP},     32'h0);
        checkOutput("a10_c4_hrdata", HRDATA,             32'h00C0_FFEE);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
